alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_if.sv | 29 ++
 rtl/alu_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester channel of the shared-ALU arbiter: one operation request plus
// the matching response, each with its own valid/ready handshake.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4
);
  logic              valid;
  logic              ready;
  logic [CTL_W-1:0]  ctl;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              err;

  // Requester side
  modport master (
    output valid, ctl, a, b, rsp_ready,
    input  ready, rsp_valid, result, zero, err
  );

  // Arbiter side
  modport slave (
    input  valid, ctl, a, b, rsp_ready,
    output ready, rsp_valid, result, zero, err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters. Round-robin
// arbitration in IDLE, one registered issue cycle (EXEC) and a held response
// (RESP) back to the owning port. Only one operation is ever in flight.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  port0,
  alu_share_arbiter_if.slave  port1,
  output logic [CTL_W-1:0]    alu_ctl,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero
);

  // Code 15 is the only control value the ALU decoder never produces.
  localparam logic [CTL_W-1:0] CTL_ILLEGAL = CTL_W'(15);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg;
  logic              owner_reg;
  logic              err_reg;
  logic              rsp_err_reg;
  logic              zero_reg;
  logic [DATA_W-1:0] result_reg;
  logic [CTL_W-1:0]  alu_ctl_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;

  logic              grant;
  logic              grant_valid;
  logic              accept;
  logic              owner_rsp_ready;
  logic              ready0, ready1;
  logic              rsp_valid0, rsp_valid1;
  logic [CTL_W-1:0]  win_ctl;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  always_comb begin
    grant_valid = port0.valid | port1.valid;
    if (port0.valid && port1.valid) begin
      grant = ~last_grant_reg;
    end else begin
      grant = port1.valid;
    end
    win_ctl = grant ? port1.ctl : port0.ctl;
    win_a   = grant ? port1.a   : port0.a;
    win_b   = grant ? port1.b   : port0.b;
  end

  assign owner_rsp_ready = owner_reg ? port1.rsp_ready : port0.rsp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs; ready never looks at response ready.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          accept     = 1'b1;
          ready0     = ~grant;
          ready1     = grant;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid0 = ~owner_reg;
        rsp_valid1 = owner_reg;
        if (owner_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand issue on accept, result capture in EXEC, arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      err_reg        <= 1'b0;
      rsp_err_reg    <= 1'b0;
      zero_reg       <= 1'b0;
      result_reg     <= '0;
      alu_ctl_reg    <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
    end else begin
      if (accept) begin
        alu_ctl_reg    <= win_ctl;
        alu_a_reg      <= win_a;
        alu_b_reg      <= win_b;
        owner_reg      <= grant;
        last_grant_reg <= grant;
        err_reg        <= (win_ctl == CTL_ILLEGAL);
      end
      if (state_reg == EXEC) begin
        result_reg  <= err_reg ? '0 : alu_result;
        zero_reg    <= err_reg ? 1'b0 : alu_zero;
        rsp_err_reg <= err_reg;
      end
    end
  end

  assign alu_ctl = alu_ctl_reg;
  assign alu_a   = alu_a_reg;
  assign alu_b   = alu_b_reg;

  assign port0.ready     = ready0;
  assign port1.ready     = ready1;
  assign port0.rsp_valid = rsp_valid0;
  assign port1.rsp_valid = rsp_valid1;

  // Response fields are shown only on the owning port; the other port reads 0.
  assign port0.result = owner_reg ? '0 : result_reg;
  assign port0.zero   = owner_reg ? 1'b0 : zero_reg;
  assign port0.err    = owner_reg ? 1'b0 : rsp_err_reg;
  assign port1.result = owner_reg ? result_reg : '0;
  assign port1.zero   = owner_reg ? zero_reg : 1'b0;
  assign port1.err    = owner_reg ? rsp_err_reg : 1'b0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed operations, hand-computed responses
// queued in a scoreboard and checked by an independent response monitor.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  alu_share_arbiter_if #(.DATA_W(32), .CTL_W(4)) p0 ();
  alu_share_arbiter_if #(.DATA_W(32), .CTL_W(4)) p1 ();

  alu_share_arbiter #(.DATA_W(32), .CTL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .port0      (p0),
    .port1      (p1),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU covering the codes the stimulus uses.
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a << alu_b[4:0];
      4'd9:    alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic        port;
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic port, input logic [31:0] result,
                          input logic zero, input logic err);
    exp_t e;
    e.port = port; e.result = result; e.zero = zero; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (p0.rsp_valid || p1.rsp_valid)
        check("rsp_onehot", {31'd0, p0.rsp_valid & p1.rsp_valid}, 32'd0);
      if (p0.ready || p1.ready)
        check("req_ready_onehot", {31'd0, p0.ready & p1.ready}, 32'd0);
      if ((p0.rsp_valid && p0.rsp_ready) || (p1.rsp_valid && p1.rsp_ready)) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          logic        port;
          logic [31:0] res;
          logic        z, er;
          e    = sb_q.pop_front();
          port = p1.rsp_valid;
          res  = port ? p1.result : p0.result;
          z    = port ? p1.zero : p0.zero;
          er   = port ? p1.err : p0.err;
          $display("[TB] rsp port=%0d result=0x%0h zero=%0d err=%0d", port, res, z, er);
          check("rsp_port",   {31'd0, port}, {31'd0, e.port});
          check("rsp_result", res, e.result);
          check("rsp_zero",   {31'd0, z},  {31'd0, e.zero});
          check("rsp_err",    {31'd0, er}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic drive_req(input logic port, input logic v, input logic [3:0] ctl,
                           input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      p1.valid = v; p1.ctl = ctl; p1.a = a; p1.b = b;
    end else begin
      p0.valid = v; p0.ctl = ctl; p0.a = a; p0.b = b;
    end
  endtask

  // Issue one operation on a port and wait for its response handshake.
  task automatic run_op(input logic port, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input logic ee);
    bit got;
    push_exp(port, er, ez, ee);
    $display("[TB] req port=%0d ctl=%0d a=0x%0h b=0x%0h", port, ctl, a, b);
    drive_req(port, 1'b1, ctl, a, b);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (port ? p1.ready : p0.ready) begin got = 1; break; end
      tick();
    end
    if (!got) check("accept_timeout", 32'd1, 32'd0);
    tick();
    drive_req(port, 1'b0, 4'd0, 32'd0, 32'd0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (port ? (p1.rsp_valid && p1.rsp_ready) : (p0.rsp_valid && p0.rsp_ready)) begin
        got = 1; break;
      end
      tick();
    end
    if (!got) check("rsp_timeout", 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit exp_seq [4];
    int n;
    int last_c;
    bit got;

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;

    // Reset values
    tick(); tick();
    check("rst_ready0",     {31'd0, p0.ready}, 32'd0);
    check("rst_ready1",     {31'd0, p1.ready}, 32'd0);
    check("rst_rsp_valid0", {31'd0, p0.rsp_valid}, 32'd0);
    check("rst_rsp_valid1", {31'd0, p1.rsp_valid}, 32'd0);
    check("rst_result0",    p0.result, 32'd0);
    check("rst_zero0",      {31'd0, p0.zero}, 32'd0);
    check("rst_err0",       {31'd0, p0.err}, 32'd0);
    check("rst_alu_ctl",    {28'd0, alu_ctl}, 32'd0);
    check("rst_alu_a",      alu_a, 32'd0);
    check("rst_alu_b",      alu_b, 32'd0);
    rst = 1'b0;
    tick();

    // Single op with latency checks: ADD 5+7
    push_exp(1'b0, 32'd12, 1'b0, 1'b0);
    $display("[TB] req port=0 ctl=0 a=0x5 b=0x7");
    drive_req(1'b0, 1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    check("single_ready0", {31'd0, p0.ready}, 32'd1);
    check("single_ready1", {31'd0, p1.ready}, 32'd0);
    tick();
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    check("single_alu_ctl",   {28'd0, alu_ctl}, 32'd0);
    check("single_alu_a",     alu_a, 32'd5);
    check("single_alu_b",     alu_b, 32'd7);
    check("single_exec_rspv", {31'd0, p0.rsp_valid}, 32'd0);
    tick();
    check("single_rsp_valid0", {31'd0, p0.rsp_valid}, 32'd1);
    check("single_rsp_valid1", {31'd0, p1.rsp_valid}, 32'd0);
    check("single_rsp_result", p0.result, 32'd12);
    tick();
    check("single_drain", sb_q.size(), 32'd0);

    // Tie round-robin from a fresh reset: expect 0,1,0,1 at 3-cycle spacing
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) push_exp(exp_seq[k], 32'd0, 1'b1, 1'b0);
    $display("[TB] req tie ports=0,1 ctl=1 a=0x9 b=0x9 x4");
    drive_req(1'b0, 1'b1, 4'd1, 32'd9, 32'd9);
    drive_req(1'b1, 1'b1, 4'd1, 32'd9, 32'd9);
    n = 0; last_c = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (p0.ready || p1.ready) begin
        check("tie_grant", {31'd0, p1.ready}, {31'd0, exp_seq[n]});
        if (n > 0) check("tie_spacing", c - last_c, 32'd3);
        last_c = c;
        n++;
      end
      tick();
    end
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    check("tie_accepts", n, 32'd4);
    repeat (5) tick();
    check("tie_drain", sb_q.size(), 32'd0);

    // Backpressure on port 1 while port 0 waits
    p1.rsp_ready = 1'b0;
    push_exp(1'b1, 32'h30, 1'b0, 1'b0);
    $display("[TB] req port=1 ctl=9 a=0xf0 b=0x3c");
    drive_req(1'b1, 1'b1, 4'd9, 32'hF0, 32'h3C);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (p1.ready) begin got = 1; break; end
      tick();
    end
    if (!got) check("bp_accept_timeout", 32'd1, 32'd0);
    tick();
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    push_exp(1'b0, 32'd2, 1'b0, 1'b0);
    $display("[TB] req port=0 ctl=0 a=0x1 b=0x1");
    drive_req(1'b0, 1'b1, 4'd0, 32'd1, 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rsp_valid1", {31'd0, p1.rsp_valid}, 32'd1);
      check("bp_result1",    p1.result, 32'h30);
      check("bp_ready0",     {31'd0, p0.ready}, 32'd0);
      tick();
    end
    p1.rsp_ready = 1'b1;
    #1;
    check("bp_ready0_release", {31'd0, p0.ready}, 32'd0);
    tick();
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (p0.ready) begin got = 1; break; end
      tick();
    end
    if (!got) check("bp_next_accept_timeout", 32'd1, 32'd0);
    tick();
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (4) tick();
    check("bp_drain", sb_q.size(), 32'd0);

    // Reset during EXEC
    $display("[TB] req port=0 ctl=0 a=0x3 b=0x4 (reset in EXEC)");
    drive_req(1'b0, 1'b1, 4'd0, 32'd3, 32'd4);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (p0.ready) begin got = 1; break; end
      tick();
    end
    if (!got) check("rexec_accept_timeout", 32'd1, 32'd0);
    tick();
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    check("rexec_alu_a_issued", alu_a, 32'd3);
    rst = 1'b1;
    tick();
    check("rexec_rsp_valid0", {31'd0, p0.rsp_valid}, 32'd0);
    check("rexec_alu_ctl",    {28'd0, alu_ctl}, 32'd0);
    check("rexec_alu_a",      alu_a, 32'd0);
    check("rexec_alu_b",      alu_b, 32'd0);
    check("rexec_result0",    p0.result, 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("rexec_no_rsp", {30'd0, p0.rsp_valid, p1.rsp_valid}, 32'd0);

    // Reset during RESP (held by backpressure)
    p1.rsp_ready = 1'b0;
    $display("[TB] req port=1 ctl=0 a=0x3 b=0x4 (reset in RESP)");
    drive_req(1'b1, 1'b1, 4'd0, 32'd3, 32'd4);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (p1.ready) begin got = 1; break; end
      tick();
    end
    if (!got) check("rresp_accept_timeout", 32'd1, 32'd0);
    tick();
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    check("rresp_held_valid1", {31'd0, p1.rsp_valid}, 32'd1);
    check("rresp_held_result", p1.result, 32'd7);
    rst = 1'b1;
    tick();
    check("rresp_rsp_valid1", {31'd0, p1.rsp_valid}, 32'd0);
    check("rresp_result1",    p1.result, 32'd0);
    check("rresp_alu_a",      alu_a, 32'd0);
    rst = 1'b0;
    p1.rsp_ready = 1'b1;
    tick();

    // First tie after reset goes to port 0
    push_exp(1'b0, 32'd7, 1'b0, 1'b0);
    $display("[TB] req tie ports=0,1 ctl=0 a=0x3 b=0x4");
    drive_req(1'b0, 1'b1, 4'd0, 32'd3, 32'd4);
    drive_req(1'b1, 1'b1, 4'd0, 32'd3, 32'd4);
    #1;
    check("rtie_ready0", {31'd0, p0.ready}, 32'd1);
    check("rtie_ready1", {31'd0, p1.ready}, 32'd0);
    tick();
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (4) tick();
    check("rtie_drain", sb_q.size(), 32'd0);

    // Illegal control code, then a legal one clears err
    run_op(1'b0, 4'd15, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
    run_op(1'b0, 4'd0,  32'd1, 32'd2, 32'd3, 1'b0, 1'b0);

    // Single requester streaming on port 1
    run_op(1'b1, 4'd0, 32'd2, 32'd3, 32'd5,  1'b0, 1'b0);
    run_op(1'b1, 4'd2, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0);

    repeat (3) tick();
    check("final_drain", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
